// File: rtl/atari_audio_pkg.sv
// Shared constants and types for the Atari audio serial output path.
// Used by i2s_audio_tx and its bit-clock generator.
package atari_audio_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int FRAME_BITS  = 2 * SAMPLE_BITS;
    localparam int BIT_CNT_W   = $clog2(FRAME_BITS);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] left;
        logic [SAMPLE_BITS-1:0] right;
    } stereo_pair_t;

    // What the shifter receives at a frame boundary.
    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_FRESH,
        LOAD_REPEAT
    } load_kind_t;

    function automatic stereo_pair_t pack_pair(
        input logic [SAMPLE_BITS-1:0] l,
        input logic [SAMPLE_BITS-1:0] r
    );
        stereo_pair_t p;
        p.left  = l;
        p.right = r;
        return p;
    endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: BCK toggles every CLK_DIV clk cycles; the tick outputs
// are high in the clk cycle whose edge performs the matching BCK transition.
module i2s_bck_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    output logic bck,
    output logic fall_tick,
    output logic rise_tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_div_cnt;
    logic       r_bck;
    logic       w_terminal;

    assign w_terminal = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bck     <= 1'b0;
        end else if (w_terminal) begin
            r_div_cnt <= '0;
            r_bck     <= ~r_bck;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    assign bck       = r_bck;
    assign fall_tick = w_terminal & r_bck;
    assign rise_tick = w_terminal & ~r_bck;

endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter with a one-pair hold buffer and underrun repeat.
// Define I2S_LJ_FORMAT_EN for left-justified framing (default: Philips I2S).
module i2s_audio_tx
    import atari_audio_pkg::*;
#(
    parameter int CLK_DIV     = 8,
    parameter int SAMPLE_BITS = atari_audio_pkg::SAMPLE_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SAMPLE_BITS-1:0] sample_l,
    input  logic [SAMPLE_BITS-1:0] sample_r,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   i2s_bck,
    output logic                   i2s_lrck,
    output logic                   i2s_data,
    output logic                   underrun
);

    logic                  w_bck;
    logic                  w_fall_tick;
    logic                  w_unused_rise_tick;

    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shifter;
    stereo_pair_t          r_hold;
    stereo_pair_t          r_prev;
    logic                  r_hold_full;
    logic                  r_ready;
    logic                  r_underrun;

    logic                  w_accept;
    logic                  w_frame_load;
    logic                  w_hold_full_next;
    load_kind_t            w_load_kind;
    logic [FRAME_BITS-1:0] w_load_word;

    i2s_bck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bck_gen (
        .clk       (clk),
        .reset     (reset),
        .bck       (w_bck),
        .fall_tick (w_fall_tick),
        .rise_tick (w_unused_rise_tick)
    );

    assign w_accept     = sample_valid & r_ready;
    assign w_frame_load = w_fall_tick & (r_bit_cnt == LAST_BIT);

    // An empty buffer at a frame boundary replays the last pair; a pair
    // accepted on that same edge waits in the buffer for the next frame.
    always_comb begin
        w_load_kind      = LOAD_NONE;
        w_load_word      = r_shifter;
        w_hold_full_next = r_hold_full;
        if (w_frame_load) begin
            if (r_hold_full) begin
                w_load_kind      = LOAD_FRESH;
                w_load_word      = r_hold;
                w_hold_full_next = 1'b0;
            end else begin
                w_load_kind = LOAD_REPEAT;
                w_load_word = r_prev;
            end
        end
        if (w_accept) begin
            w_hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shifter <= '0;
        end else if (w_fall_tick) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_load_kind != LOAD_NONE) begin
                r_shifter <= w_load_word;
            end else begin
                r_shifter <= {r_shifter[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_prev      <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_hold_full <= w_hold_full_next;
            r_ready     <= ~w_hold_full_next;
            r_underrun  <= (w_load_kind == LOAD_REPEAT);
            if (w_accept) begin
                r_hold <= pack_pair(sample_l, sample_r);
            end
            if (w_load_kind == LOAD_FRESH) begin
                r_prev <= r_hold;
            end
        end
    end

`ifdef I2S_LJ_FORMAT_EN
    assign i2s_data = r_shifter[FRAME_BITS-1];
`else
    // One-BCK lag: bit_cnt 0 still carries the previous frame's right LSB.
    logic r_data_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_dly <= 1'b0;
        end else if (w_fall_tick) begin
            r_data_dly <= r_shifter[FRAME_BITS-1];
        end
    end

    assign i2s_data = r_data_dly;
`endif

    assign i2s_bck      = w_bck;
    assign i2s_lrck     = r_bit_cnt[BIT_CNT_W-1];
    assign sample_ready = r_ready;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx (CLK_DIV=2): a cycle-count model of the
// serial stream plus directed framing, underrun, back-pressure and reset checks.
module tb_i2s_audio_tx;

    localparam int D         = 2;
    localparam int FRAME_CLK = 64 * D;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [15:0] sample_l     = '0;
    logic [15:0] sample_r     = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        i2s_bck;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        underrun;

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int lastFall     = -1;
    int prevFall     = -1;
    int underrunSeen = 0;
    bit prevLrck     = 1'b0;

    // Model state: clk edges since reset release, hold buffer and words on the wire.
    int          mk     = 0;
    bit          mFull  = 1'b0;
    bit          mReady = 1'b0;
    bit          mUnder = 1'b0;
    logic [31:0] mHold  = '0;
    logic [31:0] mPrev  = '0;
    logic [31:0] mCur   = '0;
    logic [31:0] mLast  = '0;

    logic [31:0] bpTable [5];

    always #5 clk = ~clk;

    i2s_audio_tx #(
        .CLK_DIV     (D),
        .SAMPLE_BITS (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bck      (i2s_bck),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .underrun     (underrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout expected event (t=%0t)", name, $time);
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input logic v);
        sample_l     = l;
        sample_r     = r;
        sample_valid = v;
    endtask

    function automatic logic expBck(input int k);
        return ((k / D) % 2) == 1;
    endfunction

    function automatic logic expLrck(input int k);
        return ((k / (2 * D)) % 32) >= 16;
    endfunction

    // Bit on the wire during bit slot b of the frame holding word cur.
    function automatic logic expData(input int k, input logic [31:0] cur, input logic [31:0] last);
        int b;
        b = (k / (2 * D)) % 32;
`ifdef I2S_LJ_FORMAT_EN
        return cur[31 - b] | (last[0] & 1'b0);
`else
        if (b == 0) return last[0];
        return cur[32 - b];
`endif
    endfunction

    // Model advance: a new frame every FRAME_CLK edges, one-entry buffer, ready lags one edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mk = 0; mFull = 1'b0; mReady = 1'b0; mUnder = 1'b0;
            mHold = '0; mPrev = '0; mCur = '0; mLast = '0;
        end else begin
            bit acc;
            acc    = sample_valid && mReady;
            mk     = mk + 1;
            mUnder = 1'b0;
            if (mk % FRAME_CLK == 0) begin
                mLast = mCur;
                if (mFull) begin
                    mCur  = mHold;
                    mPrev = mHold;
                    mFull = 1'b0;
                end else begin
                    mCur   = mPrev;
                    mUnder = 1'b1;
                end
            end
            if (acc) begin
                mHold = {sample_l, sample_r};
                mFull = 1'b1;
            end
            mReady = !mFull;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("bck",          32'(i2s_bck),      32'(expBck(mk)));
        checkOutput("lrck",         32'(i2s_lrck),     32'(expLrck(mk)));
        checkOutput("data",         32'(i2s_data),     32'(expData(mk, mCur, mLast)));
        checkOutput("sample_ready", 32'(sample_ready), 32'(mReady));
        checkOutput("underrun",     32'(underrun),     32'(mUnder));
        if (prevLrck && !i2s_lrck) begin
            prevFall = lastFall;
            lastFall = cyc;
        end
        prevLrck = i2s_lrck;
        if (underrun === 1'b1) underrunSeen++;
        cyc++;
    end

    task automatic waitAccept(output bit ok);
        bit rdy;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            rdy = sample_ready;
            @(negedge clk);
            if (rdy) ok = 1'b1;
        end
        if (!ok) reportTimeout("accept_wait");
    endtask

    task automatic waitBckRise(output int cycles);
        bit prevB;
        bit ok;
        prevB  = i2s_bck;
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            cycles++;
            if (!prevB && i2s_bck) ok = 1'b1;
            prevB = i2s_bck;
        end
        if (!ok) reportTimeout("bck_rise_wait");
    endtask

    task automatic waitLrckFall(output int ones);
        bit prevL;
        bit ok;
        prevL = i2s_lrck;
        ok    = 1'b0;
        ones  = 0;
        for (int i = 0; i < 3 * FRAME_CLK && !ok; i++) begin
            @(negedge clk);
            if (prevL && !i2s_lrck) begin
                ok = 1'b1;
            end else if (i2s_data) begin
                ones++;
            end
            prevL = i2s_lrck;
        end
        if (!ok) reportTimeout("lrck_fall_wait");
    endtask

    task automatic captureFrame(output logic [31:0] word);
        bit prevB;
        int got;
        int skip;
        prevB = i2s_bck;
        got   = 0;
`ifdef I2S_LJ_FORMAT_EN
        skip = 0;
`else
        skip = 1;
`endif
        word = '0;
        for (int i = 0; i < 2 * FRAME_CLK && got < 32; i++) begin
            @(negedge clk);
            if (!prevB && i2s_bck) begin
                if (skip > 0) begin
                    skip--;
                end else begin
                    word = {word[30:0], i2s_data};
                    got++;
                end
            end
            prevB = i2s_bck;
        end
        if (got < 32) reportTimeout("frame_capture");
    endtask

    initial begin
        bit          ok;
        bit          rdyPrev;
        bit          prevL;
        int          ones;
        int          n;
        int          accepts;
        int          idx;
        int          accCyc[$];
        logic [31:0] word;

        bpTable[0] = 32'h1234_ABCD;
        bpTable[1] = 32'h0000_0001;
        bpTable[2] = 32'h5555_AAAA;
        bpTable[3] = 32'h8000_7FFF;
        bpTable[4] = 32'hFFFF_FFFF;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(sample_ready), 32'd0);
        checkOutput("reset_data",  32'(i2s_data),     32'd0);

        // Release, then a single pair ahead of the first frame load.
        reset = 1'b0;
        applyStimulus(16'h8001, 16'h7FFE, 1'b1);
        @(negedge clk);
        checkOutput("ready_one_clk_after_release", 32'(sample_ready), 32'd1);
        waitAccept(ok);
        applyStimulus(16'h0000, 16'h0000, 1'b0);

        waitBckRise(n);
        waitBckRise(n);
        checkOutput("bck_period_clk", 32'(n), 32'd4);

        waitLrckFall(ones);
        checkOutput("frame0_data_ones", 32'(ones), 32'd0);
        captureFrame(word);
        checkOutput("frame1_word", word, 32'h8001_7FFE);

        // No new pairs: the same pair is replayed with an underrun per frame.
        waitLrckFall(ones);
        captureFrame(word);
        checkOutput("repeat_word", word, 32'h8001_7FFE);
        n = 0;
        while (mk < 4 * FRAME_CLK + 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("underrun_pulses", 32'(underrunSeen), 32'd3);
        checkOutput("lrck_period_clk", 32'(lastFall - prevFall), 32'd128);

        // Back-pressure: valid held high, a new pair offered after each accept.
        idx = 0;
        applyStimulus(bpTable[0][31:16], bpTable[0][15:0], 1'b1);
        waitAccept(ok);
        idx = 1;
        applyStimulus(bpTable[1][31:16], bpTable[1][15:0], 1'b1);
        accepts = 0;
        rdyPrev = sample_ready;
        for (int i = 0; i < 4 * FRAME_CLK; i++) begin
            @(negedge clk);
            if (rdyPrev) begin
                accepts++;
                accCyc.push_back(i);
                checkOutput("ready_low_after_accept", 32'(sample_ready), 32'd0);
                idx++;
                applyStimulus(bpTable[idx % 5][31:16], bpTable[idx % 5][15:0], 1'b1);
            end
            rdyPrev = sample_ready;
        end
        applyStimulus(16'h0000, 16'h0000, 1'b0);
        checkOutput("accepts_per_512clk", 32'(accepts), 32'd4);
        for (int i = 1; i < accCyc.size(); i++) begin
            checkOutput("accept_interval_clk", 32'(accCyc[i] - accCyc[i-1]), 32'd128);
        end

        // Mid-frame reset at bit slot 9 while BCK and data are both high.
        n = 0;
        while (!(((mk / (2 * D)) % 32) == 9 && expBck(mk) && expData(mk, mCur, mLast)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) reportTimeout("bit9_wait");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_bck",      32'(i2s_bck),      32'd0);
        checkOutput("midreset_lrck",     32'(i2s_lrck),     32'd0);
        checkOutput("midreset_data",     32'(i2s_data),     32'd0);
        checkOutput("midreset_underrun", 32'(underrun),     32'd0);
        checkOutput("midreset_ready",    32'(sample_ready), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n = 1;
        checkOutput("ready_after_midreset", 32'(sample_ready), 32'd1);
        prevL = i2s_lrck;
        ok    = 1'b0;
        for (int i = 0; i < 3 * FRAME_CLK && !ok; i++) begin
            @(negedge clk);
            n++;
            if (!prevL && i2s_lrck) ok = 1'b1;
            prevL = i2s_lrck;
        end
        if (!ok) reportTimeout("lrck_rise_wait");
        else checkOutput("lrck_rise_after_release_clk", 32'(n), 32'd64);

        repeat (200) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
